fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, NOP encoding and phase decoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned CPU_INSN_W = 16;
    localparam logic [CPU_INSN_W-1:0] NOP_INSN = '0;

    // Decoded view of the four one-hot phase strobes
    typedef enum logic [2:0] {
        PhFetch,
        PhDecode,
        PhExec,
        PhRdmem,
        PhIllegal
    } phase_e;

    // Phase vector is ordered {fetch, decode, exec, rdmem}; anything not one-hot is illegal
    function automatic phase_e decode_phase(input logic [3:0] ph);
        phase_e res;
        unique case (ph)
            4'b1000: res = PhFetch;
            4'b0100: res = PhDecode;
            4'b0010: res = PhExec;
            4'b0001: res = PhRdmem;
            default: res = PhIllegal;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, instruction register and load-data register,
// sequenced by an external one-hot phase generator.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter int unsigned INSN_W   = CPU_INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              phase_fetch,
    input  logic              phase_decode,
    input  logic              phase_exec,
    input  logic              phase_rdmem,
    input  logic [INSN_W-1:0] mem_rdata,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] pc,
    output logic [INSN_W-1:0] insn,
    output logic [INSN_W-1:0] load_data,
    output logic              phase_err
);

    phase_e phase;

    logic [ADDR_W-1:0] pc_q;
    logic [INSN_W-1:0] insn_q;
    logic [INSN_W-1:0] load_data_q;
    logic              phase_err_q;

    assign phase     = decode_phase({phase_fetch, phase_decode, phase_exec, phase_rdmem});
    assign pc        = pc_q;
    assign insn      = insn_q;
    assign load_data = load_data_q;
    assign phase_err = phase_err_q;

    // Memory port: PC during fetch, data address during rdmem, idle PC otherwise
    always_comb begin
        mem_addr = pc_q;
        mem_rd   = 1'b0;
        case (phase)
            PhFetch: begin
                mem_addr = pc_q;
                mem_rd   = 1'b1;
            end
            PhRdmem: begin
                mem_addr = data_addr;
                mem_rd   = load_req;
            end
            default: ;
        endcase
    end

    // Register updates at the posedge that ends each phase; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            insn_q      <= INSN_W'(NOP_INSN);
            load_data_q <= '0;
            phase_err_q <= 1'b0;
        end else begin
            case (phase)
                PhFetch: begin
                    insn_q <= mem_rdata;
                    pc_q   <= pc_q + ADDR_W'(2);
                end
                PhExec: begin
                    // Instructions are halfword aligned, so the target LSB is dropped
                    if (jump) pc_q <= {jump_addr[ADDR_W-1:1], 1'b0};
                end
                PhRdmem: begin
                    if (load_req) load_data_q <= mem_rdata;
                end
                PhIllegal: phase_err_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        phase_fetch, phase_decode, phase_exec, phase_rdmem;
    logic [15:0] mem_rdata;
    logic        jump;
    logic [15:0] jump_addr;
    logic        load_req;
    logic [15:0] data_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] pc;
    logic [15:0] insn;
    logic [15:0] load_data;
    logic        phase_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .INSN_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .phase_fetch  (phase_fetch),
        .phase_decode (phase_decode),
        .phase_exec   (phase_exec),
        .phase_rdmem  (phase_rdmem),
        .mem_rdata    (mem_rdata),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .load_req     (load_req),
        .data_addr    (data_addr),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .pc           (pc),
        .insn         (insn),
        .load_data    (load_data),
        .phase_err    (phase_err)
    );

    // {fetch, decode, exec, rdmem}
    task automatic set_phase(input logic [3:0] v);
        {phase_fetch, phase_decode, phase_exec, phase_rdmem} = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; jump = 1'b0; jump_addr = '0; load_req = 1'b0; data_addr = '0;
        mem_rdata = 16'hDEAD;
        set_phase(4'b1000);
        tick();
        tick();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        n_cmp++; if (insn !== 16'h0000) begin n_bad++; $display("FAIL reset_insn got=%h exp=0000", insn); end
        n_cmp++; if (load_data !== 16'h0000) begin n_bad++; $display("FAIL reset_ld got=%h exp=0000", load_data); end
        n_cmp++; if (phase_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", phase_err); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        mem_rdata = 16'h1234;
        set_phase(4'b1000);
        n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL fetch_addr got=%h exp=0000", mem_addr); end
        n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL fetch_rd got=%b exp=1", mem_rd); end
        tick();
        n_cmp++; if (insn !== 16'h1234) begin n_bad++; $display("FAIL fetch_insn got=%h exp=1234", insn); end
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL fetch_pc got=%h exp=0002", pc); end
        // Decode holds everything, and jump/load requests are ignored here
        mem_rdata = 16'h5555; jump = 1'b1; jump_addr = 16'h0F00; load_req = 1'b1;
        set_phase(4'b0100);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL decode_rd got=%b exp=0", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h0002) begin n_bad++; $display("FAIL decode_addr got=%h exp=0002", mem_addr); end
        tick();
        n_cmp++; if (insn !== 16'h1234) begin n_bad++; $display("FAIL decode_insn got=%h exp=1234", insn); end
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL decode_pc got=%h exp=0002", pc); end
        n_cmp++; if (load_data !== 16'h0000) begin n_bad++; $display("FAIL decode_ld got=%h exp=0000", load_data); end
        jump = 1'b0; load_req = 1'b0;
    endtask

    task automatic test_jump();
        jump = 1'b0; jump_addr = 16'h0700;
        set_phase(4'b0010);
        tick();
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL nojump_pc got=%h exp=0002", pc); end
        jump = 1'b1; jump_addr = 16'h0101;
        set_phase(4'b0010);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL exec_rd got=%b exp=0", mem_rd); end
        tick();
        n_cmp++; if (pc !== 16'h0100) begin n_bad++; $display("FAIL jump_pc got=%h exp=0100", pc); end
        jump = 1'b0;
        mem_rdata = 16'h2222;
        set_phase(4'b1000);
        n_cmp++; if (mem_addr !== 16'h0100) begin n_bad++; $display("FAIL jump_fetch_addr got=%h exp=0100", mem_addr); end
        tick();
        n_cmp++; if (pc !== 16'h0102) begin n_bad++; $display("FAIL jump_fetch_pc got=%h exp=0102", pc); end
        n_cmp++; if (insn !== 16'h2222) begin n_bad++; $display("FAIL jump_fetch_insn got=%h exp=2222", insn); end
    endtask

    task automatic test_load();
        load_req = 1'b1; data_addr = 16'h8000; mem_rdata = 16'hBEEF;
        set_phase(4'b0001);
        n_cmp++; if (mem_addr !== 16'h8000) begin n_bad++; $display("FAIL load_addr got=%h exp=8000", mem_addr); end
        n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL load_rd got=%b exp=1", mem_rd); end
        tick();
        n_cmp++; if (load_data !== 16'hBEEF) begin n_bad++; $display("FAIL load_data got=%h exp=BEEF", load_data); end
        n_cmp++; if (pc !== 16'h0102) begin n_bad++; $display("FAIL load_pc got=%h exp=0102", pc); end
        load_req = 1'b0; mem_rdata = 16'h1111;
        set_phase(4'b0001);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL noload_rd got=%b exp=0", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h8000) begin n_bad++; $display("FAIL noload_addr got=%h exp=8000", mem_addr); end
        tick();
        n_cmp++; if (load_data !== 16'hBEEF) begin n_bad++; $display("FAIL noload_data got=%h exp=BEEF", load_data); end
        // load_req outside rdmem must not capture data
        load_req = 1'b1; mem_rdata = 16'h3333;
        set_phase(4'b0010);
        tick();
        n_cmp++; if (load_data !== 16'hBEEF) begin n_bad++; $display("FAIL exec_load_data got=%h exp=BEEF", load_data); end
        load_req = 1'b0;
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_addr = 16'hFFFF;
        set_phase(4'b0010);
        tick();
        jump = 1'b0;
        n_cmp++; if (pc !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_pre_pc got=%h exp=FFFE", pc); end
        mem_rdata = 16'hA5A5;
        set_phase(4'b1000);
        n_cmp++; if (mem_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_addr got=%h exp=FFFE", mem_addr); end
        tick();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
        n_cmp++; if (insn !== 16'hA5A5) begin n_bad++; $display("FAIL wrap_insn got=%h exp=A5A5", insn); end
    endtask

    task automatic test_illegal();
        mem_rdata = 16'h9999; jump = 1'b1; jump_addr = 16'h4000;
        load_req = 1'b1; data_addr = 16'h8000;
        set_phase(4'b0000);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL zero_hot_rd got=%b exp=0", mem_rd); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL zero_hot_addr got=%h exp=0000", mem_addr); end
        tick();
        n_cmp++; if (phase_err !== 1'b1) begin n_bad++; $display("FAIL zero_hot_err got=%b exp=1", phase_err); end
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL zero_hot_pc got=%h exp=0000", pc); end
        n_cmp++; if (insn !== 16'hA5A5) begin n_bad++; $display("FAIL zero_hot_insn got=%h exp=A5A5", insn); end
        set_phase(4'b0101);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL multi_hot_rd got=%b exp=0", mem_rd); end
        tick();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL multi_hot_pc got=%h exp=0000", pc); end
        n_cmp++; if (insn !== 16'hA5A5) begin n_bad++; $display("FAIL multi_hot_insn got=%h exp=A5A5", insn); end
        n_cmp++; if (load_data !== 16'hBEEF) begin n_bad++; $display("FAIL multi_hot_ld got=%h exp=BEEF", load_data); end
        n_cmp++; if (phase_err !== 1'b1) begin n_bad++; $display("FAIL multi_hot_err got=%b exp=1", phase_err); end
        jump = 1'b0; load_req = 1'b0; mem_rdata = 16'h4242;
        set_phase(4'b1000);
        tick();
        n_cmp++; if (phase_err !== 1'b1) begin n_bad++; $display("FAIL sticky_err got=%b exp=1", phase_err); end
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL post_err_pc got=%h exp=0002", pc); end
        n_cmp++; if (insn !== 16'h4242) begin n_bad++; $display("FAIL post_err_insn got=%h exp=4242", insn); end
    endtask

    task automatic test_reset_exec();
        jump = 1'b1; jump_addr = 16'h4444; rst = 1'b1;
        set_phase(4'b0010);
        tick();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL rst_exec_pc got=%h exp=0000", pc); end
        n_cmp++; if (insn !== 16'h0000) begin n_bad++; $display("FAIL rst_exec_insn got=%h exp=0000", insn); end
        n_cmp++; if (phase_err !== 1'b0) begin n_bad++; $display("FAIL rst_exec_err got=%b exp=0", phase_err); end
        n_cmp++; if (load_data !== 16'h0000) begin n_bad++; $display("FAIL rst_exec_ld got=%h exp=0000", load_data); end
        rst = 1'b0; jump = 1'b0; mem_rdata = 16'h7777;
        set_phase(4'b1000);
        tick();
        n_cmp++; if (insn !== 16'h7777) begin n_bad++; $display("FAIL restart_insn got=%h exp=7777", insn); end
        n_cmp++; if (pc !== 16'h0002) begin n_bad++; $display("FAIL restart_pc got=%h exp=0002", pc); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_jump();
        test_load();
        test_wrap();
        test_illegal();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
